div_unit: RTL and testbench

- Iterative radix-2 restoring divider in the EX stage; executes DIV/DIVU and returns HI/LO.
- Responder side of the hazard unit's divide handshake. The hazard unit holds div_start high while a divide sits in EX and div_ready is low, stalling IF..WB. A one-cycle div_ready pulse releases the pipeline.
- Exceptions raised in MEM kill an in-flight divide through annul.

---
 rtl/div_unit_if.sv | 37 +++
 rtl/div_unit.sv | 181 ++++++++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: divide handshake between the hazard unit (master) and the
// EX-stage iterative divider (slave). Carries the request level, operands,
// abort, result, completion pulse and busy flag.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   div_start;
    logic                   signed_div;
    logic [WIDTH-1:0]       opdata1;
    logic [WIDTH-1:0]       opdata2;
    logic                   annul;
    logic [2*WIDTH-1:0]     div_result;
    logic                   div_ready;
    logic                   div_busy;

    modport master (
        output div_start,
        output signed_div,
        output opdata1,
        output opdata2,
        output annul,
        input  div_result,
        input  div_ready,
        input  div_busy
    );

    modport slave (
        input  div_start,
        input  signed_div,
        input  opdata1,
        input  opdata2,
        input  annul,
        output div_result,
        output div_ready,
        output div_busy
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in EX.
// Result layout: [2*WIDTH-1:WIDTH] remainder (HI), [WIDTH-1:0] quotient (LO).
// Divide-by-zero returns {raw dividend, all ones}. -2^(W-1) / -1 wraps.
// Optional macro DIV_EARLY_EXIT_EN: when |dividend| < |divisor| (divisor
// nonzero) the result {dividend, 0} is produced one cycle after the start
// edge instead of after WIDTH iterations. Results are identical either way.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave div_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV0 = 2'd1,
        ON   = 2'd2,
        END  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W   = '0;
    localparam logic [WIDTH-1:0] ONES_W   = '1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Partial remainder (the restore step keeps it below the divisor).
    logic [WIDTH-1:0]   rem_q, rem_d;
    // Dividend bits shift out of the top while quotient bits shift in below.
    // In DIV0 it holds the raw dividend for the HI result.
    logic [WIDTH-1:0]   dq_q, dq_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes; only signed divides take the two's complement.
    always_comb begin
        abs1 = (div_if.signed_div && div_if.opdata1[WIDTH-1]) ? (ZERO_W - div_if.opdata1)
                                                               : div_if.opdata1;
        abs2 = (div_if.signed_div && div_if.opdata2[WIDTH-1]) ? (ZERO_W - div_if.opdata2)
                                                               : div_if.opdata2;
    end

    // One restoring iteration plus sign fix-up of the would-be final values.
    always_comb begin
        rem_shift = {rem_q, dq_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_diff[WIDTH];
        rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {dq_q[WIDTH-2:0], q_bit};
        quo_fix   = (sgn_q && (s1_q != s2_q)) ? (ZERO_W - quo_next) : quo_next;
        rem_fix   = (sgn_q && s1_q) ? (ZERO_W - rem_next) : rem_next;
    end

    // Next-state, datapath loads and completion pulse.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_if.div_start && !div_if.annul) begin
                    dvs_d = abs2;
                    s1_d  = div_if.opdata1[WIDTH-1];
                    s2_d  = div_if.opdata2[WIDTH-1];
                    sgn_d = div_if.signed_div;
                    cnt_d = '0;
                    rem_d = '0;
                    if (div_if.opdata2 == ZERO_W) begin
                        dq_d    = div_if.opdata1;
                        state_d = DIV0;
                    end else begin
                        dq_d = abs1;
`ifdef DIV_EARLY_EXIT_EN
                        // Quotient is zero and the remainder is the dividend itself,
                        // which already carries the dividend's sign.
                        if (abs1 < abs2) begin
                            result_d = {div_if.opdata1, ZERO_W};
                            ready_d  = 1'b1;
                            state_d  = END;
                        end else begin
                            state_d = ON;
                        end
`else
                        state_d = ON;
`endif
                    end
                end
            end

            DIV0: begin
                if (div_if.annul || !div_if.div_start) begin
                    state_d = IDLE;
                end else begin
                    result_d = {dq_q, ONES_W};
                    ready_d  = 1'b1;
                    state_d  = END;
                end
            end

            ON: begin
                if (div_if.annul || !div_if.div_start) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_next;
                    dq_d  = quo_next;
                    cnt_d = cnt_q + ONE_CNT;
                    if (cnt_q == LAST_CNT) begin
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                        state_d  = END;
                    end
                end
            end

            END: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign div_if.div_result = result_q;
    assign div_if.div_ready  = ready_q;
    assign div_if.div_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus hand-written sequences for abort,
// operand-change, back-to-back and reset corner cases of div_unit.
module tb_div_unit;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif
    localparam int NVEC = 13;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    logic [63:0] last_res;
    int          lat;
    int          lat2;
    logic        seen;

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        if (b == 32'd0) return 2;
        if (EARLY_EN && (ma < mb)) return 1;
        return 33;
    endfunction

    task automatic wait_ready(input int max_k, output int k_seen);
        k_seen = 0;
        for (int k = 1; k <= max_k; k++) begin
            @(posedge clk);
            #1;
            if (dif.div_ready) begin
                k_seen = k;
                return;
            end
        end
    endtask

    task automatic watch_no_ready(input int n, output logic hit);
        hit = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (dif.div_ready) hit = 1'b1;
        end
    endtask

    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.div_start  = 1'b1;
        dif.signed_div = sgn;
        dif.opdata1    = a;
        dif.opdata2    = b;
        dif.annul      = 1'b0;
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] res);
        int k;
        start_op(sgn, a, b);
        wait_ready(80, k);
        check({name, " latency"}, 64'(k), 64'(exp_lat(sgn, a, b)));
        check({name, " result"}, dif.div_result, res);
        check({name, " busy in END"}, 64'(dif.div_busy), 64'd1);
        dif.div_start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " ready drops"}, 64'(dif.div_ready), 64'd0);
        check({name, " busy drops"}, 64'(dif.div_busy), 64'd0);
        check({name, " result holds"}, dif.div_result, res);
        last_res = res;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        last_res       = 64'd0;
        rst            = 1'b1;
        dif.div_start  = 1'b0;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd0;
        dif.opdata2    = 32'd0;
        dif.annul      = 1'b0;

        vecs[0]  = '{"divu 100/7",        1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
        vecs[1]  = '{"div -100/7",        1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE,   32'hFFFFFFF2}};
        vecs[2]  = '{"div min/-1",        1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0,          32'h80000000}};
        vecs[3]  = '{"divu 5/0",          1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFFFFFF}};
        vecs[4]  = '{"divu 3/10",         1'b0, 32'd3,          32'd10,         {32'd3,          32'd0}};
        vecs[5]  = '{"div 100/-7",        1'b1, 32'd100,        32'hFFFFFFF9,   {32'd2,          32'hFFFFFFF2}};
        vecs[6]  = '{"div -100/-7",       1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE,   32'd14}};
        vecs[7]  = '{"divu max/1",        1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0,          32'hFFFFFFFF}};
        vecs[8]  = '{"divu max/max",      1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0,          32'd1}};
        vecs[9]  = '{"div -5/0",          1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB,   32'hFFFFFFFF}};
        vecs[10] = '{"div -3/10",         1'b1, 32'hFFFFFFFD,   32'd10,         {32'hFFFFFFFD,   32'd0}};
        vecs[11] = '{"divu 1000/3",       1'b0, 32'd1000,       32'd3,          {32'd1,          32'd333}};
        vecs[12] = '{"divu 0x80000000/max", 1'b0, 32'h80000000, 32'hFFFFFFFF,   {32'h80000000,   32'd0}};

        repeat (2) @(posedge clk);
        #1;
        check("reset result", dif.div_result, 64'd0);
        check("reset ready", 64'(dif.div_ready), 64'd0);
        check("reset busy", 64'(dif.div_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res);
        end

        // Annul for one cycle after iteration 10 of DIVU 1000/3.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        dif.annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul busy", 64'(dif.div_busy), 64'd0);
        check("annul ready", 64'(dif.div_ready), 64'd0);
        dif.annul     = 1'b0;
        dif.div_start = 1'b0;
        watch_no_ready(40, seen);
        check("annul no pulse", 64'(seen), 64'd0);
        check("annul result kept", dif.div_result, last_res);
        run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // Annul on the very edge that would complete the divide.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (32) @(posedge clk);
        #1;
        check("pre-completion ready", 64'(dif.div_ready), 64'd0);
        dif.annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul beats completion ready", 64'(dif.div_ready), 64'd0);
        check("annul beats completion busy", 64'(dif.div_busy), 64'd0);
        check("annul beats completion result", dif.div_result, last_res);
        dif.annul     = 1'b0;
        dif.div_start = 1'b0;
        watch_no_ready(5, seen);
        check("annul completion no pulse", 64'(seen), 64'd0);

        // Drop div_start mid-ON.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        #1;
        dif.div_start = 1'b0;
        @(posedge clk);
        #1;
        check("drop start busy", 64'(dif.div_busy), 64'd0);
        watch_no_ready(5, seen);
        check("drop start no pulse", 64'(seen), 64'd0);
        check("drop start result kept", dif.div_result, last_res);

        // Operands change mid-ON while start is held: latched values win.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #1;
        dif.opdata1 = 32'd12345;
        dif.opdata2 = 32'd1;
        wait_ready(80, lat);
        check("opchange latency", 64'(lat + 6), 64'd33);
        check("opchange result", dif.div_result, {32'd2, 32'd14});
        dif.div_start = 1'b0;
        last_res      = {32'd2, 32'd14};
        @(posedge clk);
        #1;

        // Back-to-back: start held through END, next op begins from IDLE.
        start_op(1'b0, 32'd100, 32'd7);
        wait_ready(80, lat);
        check("b2b first latency", 64'(lat), 64'd33);
        check("b2b first result", dif.div_result, {32'd2, 32'd14});
        dif.opdata1 = 32'd9;
        dif.opdata2 = 32'd3;
        wait_ready(80, lat2);
        check("b2b second latency", 64'(lat2), 64'd34);
        check("b2b second result", dif.div_result, {32'd0, 32'd3});
        dif.div_start = 1'b0;
        last_res      = {32'd0, 32'd3};
        @(posedge clk);
        #1;

        // Start and annul together in IDLE: nothing starts.
        @(negedge clk);
        dif.div_start  = 1'b1;
        dif.annul      = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd9;
        dif.opdata2    = 32'd3;
        @(posedge clk);
        #1;
        check("start+annul busy", 64'(dif.div_busy), 64'd0);
        @(posedge clk);
        #1;
        check("start+annul busy later", 64'(dif.div_busy), 64'd0);
        check("start+annul ready", 64'(dif.div_ready), 64'd0);
        dif.div_start = 1'b0;
        dif.annul     = 1'b0;

        // Asynchronous reset mid-operation.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset busy", 64'(dif.div_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async reset busy", 64'(dif.div_busy), 64'd0);
        check("async reset ready", 64'(dif.div_ready), 64'd0);
        check("async reset result", dif.div_result, 64'd0);
        dif.div_start = 1'b0;
        last_res      = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        run_div("divu 1000/3 after reset", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
